// File: rtl/dma_read_checker.sv
// Issues one DMA read command, then checks each returned beat against an incrementing
// 32-bit pattern. The optional cycle counter is enabled with `define DMA_RD_CHK_CYCLE_CNT_EN.
module dma_read_checker #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
) (
  input  logic              pcie_clk,
  input  logic              pcie_areset,
  input  logic [63:0]       ctrl_addr,
  input  logic [31:0]       ctrl_length,
  input  logic [31:0]       ctrl_offset,
  input  logic              ctrl_start,
  output logic              m_axis_dma_read_cmd_valid,
  input  logic              m_axis_dma_read_cmd_ready,
  output logic [63:0]       m_axis_dma_read_cmd_address,
  output logic [31:0]       m_axis_dma_read_cmd_length,
  input  logic              s_axis_dma_read_data_valid,
  output logic              s_axis_dma_read_data_ready,
  input  logic [DATA_W-1:0] s_axis_dma_read_data_data,
  input  logic [KEEP_W-1:0] s_axis_dma_read_data_keep,
  input  logic              s_axis_dma_read_data_last,
  output logic              stat_busy,
  output logic              stat_done,
  output logic              stat_len_err,
  output logic [31:0]       stat_error_cnt,
  output logic [31:0]       stat_first_err_idx,
  output logic [31:0]       stat_beat_cnt,
  output logic [31:0]       stat_cycle_cnt
);

  typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, DONE} state_t;

  state_t state, state_nxt;

  logic        start_s1, start_s2, start_prev, start_armed, start_rise;
  logic [1:0]  sync_fill;
  logic [31:0] exp_beats_in;
  logic        cmd_fire, beat_fire, start_acc;

  logic [63:0]       addr_q;
  logic [31:0]       len_q, off_q, exp_q, idx;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       idx_q, exp_word;
  logic              last_q, cmp_vld, mismatch;

  // byte enables are not part of the check
  logic unused_keep;
  assign unused_keep = ^s_axis_dma_read_data_keep;

  // A start level already high when reset releases must first be seen low (armed)
  // before a rising edge counts; sync_fill marks when start_s2 holds real input.
  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) begin
      start_s1    <= 1'b0;
      start_s2    <= 1'b0;
      start_prev  <= 1'b0;
      start_armed <= 1'b0;
      sync_fill   <= '0;
    end else begin
      start_s1   <= ctrl_start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      sync_fill  <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && !start_s2) start_armed <= 1'b1;
    end
  end

  assign start_rise   = start_armed && start_s2 && !start_prev;
  assign exp_beats_in = ctrl_length >> 6;
  assign start_acc    = (state == IDLE) && start_rise;

  assign m_axis_dma_read_cmd_valid   = (state == READ_CMD);
  assign m_axis_dma_read_cmd_address = addr_q;
  assign m_axis_dma_read_cmd_length  = len_q;
  assign s_axis_dma_read_data_ready  = (state == READ_DATA);
  assign stat_busy                   = (state == READ_CMD) || (state == READ_DATA);

  assign cmd_fire  = m_axis_dma_read_cmd_valid && m_axis_dma_read_cmd_ready;
  assign beat_fire = s_axis_dma_read_data_valid && s_axis_dma_read_data_ready;

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_rise) state_nxt = (exp_beats_in == 32'd0) ? DONE : READ_CMD;
      READ_CMD:  if (cmd_fire) state_nxt = READ_DATA;
      READ_DATA: if (beat_fire && s_axis_dma_read_data_last) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Beats are registered on acceptance and compared one cycle later.
  assign exp_word = idx_q + off_q;
  assign mismatch = data_q != {{(DATA_W-32){1'b0}}, exp_word};

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) begin
      addr_q             <= '0;
      len_q              <= '0;
      off_q              <= '0;
      exp_q              <= '0;
      idx                <= '0;
      data_q             <= '0;
      idx_q              <= '0;
      last_q             <= 1'b0;
      cmp_vld            <= 1'b0;
      stat_error_cnt     <= '0;
      stat_first_err_idx <= '0;
      stat_beat_cnt      <= '0;
      stat_len_err       <= 1'b0;
      stat_done          <= 1'b0;
    end else begin
      cmp_vld <= beat_fire;
      if (beat_fire) begin
        data_q <= s_axis_dma_read_data_data;
        idx_q  <= idx;
        last_q <= s_axis_dma_read_data_last;
        idx    <= idx + 32'd1;
      end
      if (start_acc) begin
        addr_q             <= ctrl_addr;
        len_q              <= ctrl_length;
        off_q              <= ctrl_offset;
        exp_q              <= exp_beats_in;
        idx                <= '0;
        stat_error_cnt     <= '0;
        stat_first_err_idx <= '0;
        stat_beat_cnt      <= '0;
        stat_len_err       <= 1'b0;
        stat_done          <= 1'b0;
      end
      if (cmp_vld) begin
        stat_beat_cnt <= stat_beat_cnt + 32'd1;
        if (mismatch) begin
          if (stat_error_cnt != '1)     stat_error_cnt     <= stat_error_cnt + 32'd1;
          if (stat_error_cnt == 32'd0)  stat_first_err_idx <= idx_q;
        end
        // early last, or the expected final beat arriving without last
        if (last_q ? (idx_q != exp_q - 32'd1) : (idx_q == exp_q - 32'd1))
          stat_len_err <= 1'b1;
      end
      // set on leaving DONE so it lines up with the final counter update
      if (state == DONE) stat_done <= 1'b1;
    end
  end

`ifdef DMA_RD_CHK_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset)
      cyc_cnt <= '0;
    else if (start_acc)
      cyc_cnt <= '0;
    else if ((cmd_fire || state == READ_DATA) && cyc_cnt != '1)
      cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign stat_cycle_cnt = cyc_cnt;
`else
  assign stat_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_read_checker.sv
// Scoreboard bench for dma_read_checker: stimulus pushes expected commands and run results,
// independent monitors pop and compare on each command handshake and each done rise.
module tb_dma_read_checker;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63:0]       ctrl_addr = '0;
  logic [31:0]       ctrl_length = '0;
  logic [31:0]       ctrl_offset = '0;
  logic              ctrl_start = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [63:0]       cmd_address;
  logic [31:0]       cmd_length;
  logic              d_valid = 1'b0;
  logic              d_ready;
  logic [DATA_W-1:0] d_data = '0;
  logic [KEEP_W-1:0] d_keep = '0;
  logic              d_last = 1'b0;
  logic              busy, done, len_err;
  logic [31:0]       err_cnt, first_idx, beat_cnt, cyc_cnt;

  dma_read_checker #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .pcie_clk(clk), .pcie_areset(rst),
    .ctrl_addr(ctrl_addr), .ctrl_length(ctrl_length), .ctrl_offset(ctrl_offset), .ctrl_start(ctrl_start),
    .m_axis_dma_read_cmd_valid(cmd_valid), .m_axis_dma_read_cmd_ready(cmd_ready),
    .m_axis_dma_read_cmd_address(cmd_address), .m_axis_dma_read_cmd_length(cmd_length),
    .s_axis_dma_read_data_valid(d_valid), .s_axis_dma_read_data_ready(d_ready),
    .s_axis_dma_read_data_data(d_data), .s_axis_dma_read_data_keep(d_keep),
    .s_axis_dma_read_data_last(d_last),
    .stat_busy(busy), .stat_done(done), .stat_len_err(len_err),
    .stat_error_cnt(err_cnt), .stat_first_err_idx(first_idx),
    .stat_beat_cnt(beat_cnt), .stat_cycle_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] errs; logic [31:0] first; logic [31:0] beats; logic len_err; } res_t;
  typedef struct { logic [63:0] addr; logic [31:0] len; } cmd_t;

  res_t exp_res_q[$];
  cmd_t exp_cmd_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cmd_fires = 0;
  bit   bad [0:255];
  int   badbit [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired waiting on DUT", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // command monitor: stability while stalled, and each handshake against the queue
  initial begin
    logic        pv, pr;
    logic [63:0] pa;
    logic [31:0] pl;
    cmd_t        c;
    pv = 0; pr = 0; pa = '0; pl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (pv && !pr) begin
          check("cmd_valid_held", cmd_valid, 1);
          check("cmd_addr_stable", cmd_address, pa);
          check("cmd_len_stable", cmd_length, pl);
        end
        if (cmd_valid && cmd_ready) begin
          cmd_fires++;
          if (exp_cmd_q.size() == 0) begin
            check("unexpected_cmd", 1, 0);
          end else begin
            c = exp_cmd_q.pop_front();
            check("cmd_addr", cmd_address, c.addr);
            check("cmd_len", cmd_length, c.len);
          end
        end
        pv = cmd_valid; pr = cmd_ready; pa = cmd_address; pl = cmd_length;
      end
    end
  end

  // result monitor: compare status once per run, when done rises
  initial begin
    logic dp;
    res_t r;
    dp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 0;
      end else begin
        if (done && !dp) begin
          if (exp_res_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            r = exp_res_q.pop_front();
            check("error_cnt", err_cnt, r.errs);
            check("first_err_idx", first_idx, r.first);
            check("beat_cnt", beat_cnt, r.beats);
            check("len_err", len_err, r.len_err);
          end
        end
        dp = done;
      end
    end
  end

  task automatic clear_bad();
    for (int i = 0; i < 256; i++) begin bad[i] = 0; badbit[i] = 0; end
  endtask

  task automatic do_start(input logic [63:0] addr, input logic [31:0] len, input logic [31:0] off);
    ctrl_start = 0;
    tick(4);
    ctrl_addr = addr; ctrl_length = len; ctrl_offset = off;
    ctrl_start = 1;
  endtask

  task automatic do_cmd(input int delay);
    int t = 0;
    while (!cmd_valid && t < 50) begin tick(1); t++; end
    if (!cmd_valid) begin fail_now("cmd_timeout"); return; end
    tick(delay);
    cmd_ready = 1;
    tick(1);
    cmd_ready = 0;
  endtask

  task automatic send_beat(input int i, input logic [31:0] off, input bit last);
    logic [DATA_W-1:0] d;
    int t = 0;
    bit acc = 0;
    d = '0;
    d[31:0] = off + i;
    if (bad[i]) d[badbit[i]] = ~d[badbit[i]];
    d_data = d; d_keep = '1; d_last = last; d_valid = 1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = d_ready;
      @(posedge clk);
      #1;
      t++;
    end
    d_valid = 0; d_last = 0;
    if (!acc) fail_now("beat_timeout");
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 300);
    if (!done) begin fail_now("done_timeout"); return; end
    tick(1);
    check("idle_busy", busy, 0);
    check("idle_data_ready", d_ready, 0);
    check("idle_cmd_valid", cmd_valid, 0);
  endtask

  // The reference result is derived from what was sent: every beat with an injected
  // corruption is one error; length is fine only if last lands on beat (length/64)-1.
  task automatic run(input logic [63:0] addr, input logic [31:0] len, input logic [31:0] off,
                     input int last_idx, input int cmd_delay, input int max_gap);
    res_t r;
    cmd_t c;
    int   exp_beats, nb;
    exp_beats = int'(len / 64);
    nb = (exp_beats == 0) ? 0 : last_idx + 1;
    r.errs = 0; r.first = 0; r.beats = nb;
    r.len_err = (exp_beats != 0) && (last_idx != exp_beats - 1);
    for (int i = 0; i < nb; i++)
      if (bad[i]) begin
        if (r.errs == 0) r.first = i;
        r.errs++;
      end
    exp_res_q.push_back(r);
    if (exp_beats != 0) begin
      c.addr = addr; c.len = len;
      exp_cmd_q.push_back(c);
    end
    do_start(addr, len, off);
    if (exp_beats != 0) begin
      do_cmd(cmd_delay);
      for (int i = 0; i < nb; i++) begin
        tick($urandom_range(0, max_gap));
        send_beat(i, off, i == last_idx);
      end
    end
    wait_done();
  endtask

  initial begin
    int f0, nbe, li;
    logic [31:0] off;
    clear_bad();
    tick(3);
    check("rst_outputs", {cmd_valid, d_ready, busy, done, len_err, err_cnt, first_idx, beat_cnt, cyc_cnt}, 0);
    rst = 0;
    tick(3);

    // clean 64-beat run, ready always high
    run(64'h0000_1000_0000_0000, 32'd4096, 32'h100, 63, 0, 0);
    check("clean_done", done, 1);

    // two corrupted beats in a 16-beat run
    bad[5] = 1; badbit[5] = 100;
    bad[9] = 1; badbit[9] = 3;
    run(64'h0000_0000_dead_0000, 32'd1024, $urandom, 15, 0, 1);
    clear_bad();

    // last arrives early on beat 7 of 10
    run(64'h40, 32'd640, 32'h7, 7, 1, 1);

    // command stalled for 20 cycles
    f0 = cmd_fires;
    run(64'hffff_0000_1234_5600, 32'd512, 32'h55, 7, 20, 0);
    check("one_cmd_accepted", cmd_fires - f0, 1);

    // reset in the middle of a 64-beat run, on beat 3
    exp_cmd_q.push_back('{addr: 64'h8000, len: 32'd4096});
    do_start(64'h8000, 32'd4096, 32'h0);
    do_cmd(0);
    for (int i = 0; i < 3; i++) send_beat(i, 32'h0, 1'b0);
    d_data = '0; d_data[31:0] = 32'd3; d_valid = 1; d_keep = '1;
    #2 rst = 1;
    #1 check("rst_mid_outputs", {cmd_valid, d_ready, busy, done, len_err, err_cnt, first_idx, beat_cnt, cyc_cnt}, 0);
    tick(2);
    d_valid = 0;
    rst = 0;
    // ctrl_start is still high across reset release: no run may start
    tick(12);
    check("no_start_after_rst_busy", busy, 0);
    check("no_start_after_rst_done", done, 0);
    check("no_start_after_rst_cmd", cmd_valid, 0);
    run(64'h8000, 32'd4096, 32'h0, 63, 2, 2);

    // length below one beat: no command
    f0 = cmd_fires;
    run(64'h1000, 32'd32, 32'h9, 0, 0, 0);
    check("zero_beat_no_cmd", cmd_fires - f0, 0);
    check("zero_beat_done", done, 1);

    // full-rate 64-beat run for the cycle counter
    run(64'h2000, 32'd4096, 32'hffff_ffe0, 63, 0, 0);
`ifdef DMA_RD_CHK_CYCLE_CNT_EN
    check("cycle_cnt_ge_64", cyc_cnt >= 32'd64, 1);
`else
    check("cycle_cnt_zero", cyc_cnt, 0);
`endif

    // randomized runs: random lengths, offsets, corruption and last placement
    for (int n = 0; n < 10; n++) begin
      clear_bad();
      nbe = $urandom_range(1, 24);
      li = ($urandom_range(0, 9) < 7) ? nbe - 1 : $urandom_range(0, nbe + 3);
      for (int i = 0; i <= li; i++)
        if ($urandom_range(0, 5) == 0) begin bad[i] = 1; badbit[i] = $urandom_range(0, DATA_W - 1); end
      off = (n == 3) ? 32'hffff_fff8 : $urandom;
      run({$urandom, $urandom}, nbe * 64 + $urandom_range(0, 63), off, li,
          $urandom_range(0, 4), $urandom_range(0, 3));
    end

    tick(4);
    check("res_queue_empty", exp_res_q.size(), 0);
    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
